multi_channel_random_generator: RTL

Parametrised, multi-channel successor to the single-channel ranged `RandomGenerator`. Each of `NUM_CHANNELS` independent channels owns a 16-bit Galois LFSR. Each channel produces signed `WIDTH`-bit values that are uniformly distributed over its own inclusive range [min, max], using mask-and-reject sampling. Results are delivered on a per-channel valid/ready handshake, so downstream MCMC sampling logic can apply backpressure. It sits between seed distribution and the constraint-solver sampling stages.

---
 rtl/multi_channel_random_generator.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/multi_channel_random_generator.sv
// multi_channel_random_generator
// NUM_CHANNELS independent ranged random sources. Each channel owns a 16-bit
// Galois LFSR and draws signed WIDTH-bit values uniformly over its inclusive
// [min, max] range by masking the LFSR to the span width and rejecting
// candidates that exceed the span. Results leave on a per-channel valid/ready
// handshake so the consumer can stall any channel without affecting others.
module multi_channel_random_generator #(
    parameter int WIDTH        = 8,
    parameter int NUM_CHANNELS = 4
) (
    input  logic                          in_clock,
    input  logic                          in_reset,
    input  logic                          in_seed_load,
    input  logic [15:0]                   in_seed,
    input  logic [NUM_CHANNELS-1:0]       in_enable,
    input  logic [NUM_CHANNELS*WIDTH-1:0] in_min,
    input  logic [NUM_CHANNELS*WIDTH-1:0] in_max,
    input  logic [NUM_CHANNELS-1:0]       in_ready,
    output logic [NUM_CHANNELS*WIDTH-1:0] out_random,
    output logic [NUM_CHANNELS-1:0]       out_valid,
    output logic [NUM_CHANNELS-1:0]       out_error
);

    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [15:0] RESET_SEED = 16'hACE1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    // One Galois right-shift step of x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ({1'b0, v[15:1]} ^ LFSR_TAPS) : {1'b0, v[15:1]};
    endfunction

    // An all-zero LFSR would lock up, so substitute the state 1.
    function automatic logic [15:0] nonzero(input logic [15:0] v);
        return (v == 16'h0000) ? 16'h0001 : v;
    endfunction

    // Ones from the most significant set bit of d downward (0 when d is 0).
    function automatic logic [WIDTH-1:0] msb_mask(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] m;
        m = d;
        for (int s = 1; s < WIDTH; s = s * 2) begin
            m = m | (m >> s);
        end
        return m;
    endfunction

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
        // Per-channel decorrelation constant mixed into every seed.
        localparam logic [15:0] K_CHAN = 16'(32'(gi) * 32'h0000_9E37);

        logic [WIDTH-1:0] min_s;
        logic [WIDTH-1:0] max_s;
        logic [WIDTH:0]   diff_wide_s;
        logic [WIDTH-1:0] diff_s;
        logic [WIDTH-1:0] mask_s;
        logic [WIDTH-1:0] cand_s;
        logic [WIDTH-1:0] sum_s;
        logic             range_bad_s;
        logic             accept_s;

        logic [1:0]       state_r;
        logic [1:0]       state_nxt_s;
        logic [15:0]      lfsr_r;
        logic [15:0]      lfsr_nxt_s;
        logic [WIDTH-1:0] random_r;
        logic [WIDTH-1:0] random_nxt_s;
        logic             valid_r;
        logic             valid_nxt_s;
        logic             error_r;
        logic             error_nxt_s;

        assign min_s = in_min[gi*WIDTH +: WIDTH];
        assign max_s = in_max[gi*WIDTH +: WIDTH];

        // Exact signed difference: one extra bit so min > max shows as a
        // negative result and a valid span fits in WIDTH unsigned bits.
        assign diff_wide_s = {max_s[WIDTH-1], max_s} - {min_s[WIDTH-1], min_s};
        assign range_bad_s = diff_wide_s[WIDTH];
        assign diff_s      = diff_wide_s[WIDTH-1:0];
        assign mask_s      = msb_mask(diff_s);
        assign cand_s      = lfsr_r[WIDTH-1:0] & mask_s;
        assign accept_s    = (cand_s <= diff_s);
        assign sum_s       = min_s + cand_s;

        // Channel FSM state register.
        always_ff @(posedge in_clock or negedge in_reset) begin
            if (!in_reset) begin
                state_r <= ST_IDLE;
            end else begin
                state_r <= state_nxt_s;
            end
        end

        // Next-state selection; a seed load forces every channel idle.
        always_comb begin
            state_nxt_s = state_r;
            if (in_seed_load) begin
                state_nxt_s = ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (in_enable[gi] && !range_bad_s) begin
                            state_nxt_s = ST_SEARCH;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end
                    ST_SEARCH: begin
                        if (!in_enable[gi] || range_bad_s) begin
                            state_nxt_s = ST_IDLE;
                        end else if (accept_s) begin
                            state_nxt_s = ST_HOLD;
                        end else begin
                            state_nxt_s = ST_SEARCH;
                        end
                    end
                    ST_HOLD: begin
                        if (in_ready[gi]) begin
                            state_nxt_s = in_enable[gi] ? ST_SEARCH : ST_IDLE;
                        end else begin
                            state_nxt_s = ST_HOLD;
                        end
                    end
                    default: begin
                        state_nxt_s = ST_IDLE;
                    end
                endcase
            end
        end

        // Next values of the LFSR and the registered outputs.
        always_comb begin
            lfsr_nxt_s   = lfsr_r;
            random_nxt_s = random_r;
            valid_nxt_s  = valid_r;
            error_nxt_s  = error_r;
            if (in_seed_load) begin
                lfsr_nxt_s  = nonzero(in_seed ^ K_CHAN);
                valid_nxt_s = 1'b0;
                error_nxt_s = 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        valid_nxt_s = 1'b0;
                        if (in_enable[gi]) begin
                            error_nxt_s = range_bad_s;
                        end else begin
                            error_nxt_s = 1'b0;
                        end
                    end
                    ST_SEARCH: begin
                        lfsr_nxt_s = lfsr_step(lfsr_r);
                        if (!in_enable[gi]) begin
                            error_nxt_s = 1'b0;
                        end else if (range_bad_s) begin
                            error_nxt_s = 1'b1;
                        end else begin
                            error_nxt_s = 1'b0;
                            if (accept_s) begin
                                random_nxt_s = sum_s;
                                valid_nxt_s  = 1'b1;
                            end else begin
                                valid_nxt_s  = valid_r;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (in_ready[gi]) begin
                            valid_nxt_s = 1'b0;
                        end else begin
                            valid_nxt_s = valid_r;
                        end
                        if (!in_enable[gi]) begin
                            error_nxt_s = 1'b0;
                        end else begin
                            error_nxt_s = error_r;
                        end
                    end
                    default: begin
                        valid_nxt_s = 1'b0;
                        error_nxt_s = 1'b0;
                    end
                endcase
            end
        end

        // Datapath registers: LFSR, held result, valid and error flags.
        always_ff @(posedge in_clock or negedge in_reset) begin
            if (!in_reset) begin
                lfsr_r   <= nonzero(RESET_SEED ^ K_CHAN);
                random_r <= {WIDTH{1'b0}};
                valid_r  <= 1'b0;
                error_r  <= 1'b0;
            end else begin
                lfsr_r   <= lfsr_nxt_s;
                random_r <= random_nxt_s;
                valid_r  <= valid_nxt_s;
                error_r  <= error_nxt_s;
            end
        end

        assign out_random[gi*WIDTH +: WIDTH] = random_r;
        assign out_valid[gi]                 = valid_r;
        assign out_error[gi]                 = error_r;
    end

endmodule
